// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and its line helpers.
`timescale 1ns/1ps

package ps2_pkg;

  // Transmitter FSM states, in frame order.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    INHIBIT   = 3'd1,
    START     = 3'd2,
    SEND      = 3'd3,
    ACK       = 3'd4,
    WAIT_IDLE = 3'd5
  } ps2_tx_state_e;

  // Keyboard commands the game top issues.
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;

  // Byte the keyboard answers with after accepting a command.
  localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

  // Frame bit positions after the start bit: 0-7 data, then parity, then stop.
  localparam logic [3:0] PS2_PARITY_IDX  = 4'd8;
  localparam logic [3:0] PS2_STOP_IDX    = 4'd9;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic ps2_odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pads plus a registered
// falling-edge pulse on the synchronized clock. Shared with the receiver.
`timescale 1ns/1ps

module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic [1:0] clk_meta_q, clk_meta_d;
  logic [1:0] data_meta_q, data_meta_d;
  logic       clk_prev_q, clk_prev_d;
  logic       fall_q, fall_d;

  // Shift pads through the synchronizers and flag a 1->0 step of the clean clock.
  always_comb begin
    clk_meta_d  = {clk_meta_q[0], ps2_clk_i};
    data_meta_d = {data_meta_q[0], ps2_data_i};
    clk_prev_d  = clk_meta_q[1];
    fall_d      = clk_prev_q & ~clk_meta_q[1];
  end

  // Idle PS/2 lines float high, so the synchronizers come out of reset at 1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_meta_q  <= 2'b11;
      data_meta_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      fall_q      <= 1'b0;
    end else begin
      clk_meta_q  <= clk_meta_d;
      data_meta_q <= data_meta_d;
      clk_prev_q  <= clk_prev_d;
      fall_q      <= fall_d;
    end
  end

  assign clk_sync  = clk_meta_q[1];
  assign data_sync = data_meta_q[1];
  assign clk_fall  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain clock/data enables.
// Optional frame watchdog: define PS2_TX_TIMEOUT_EN to abort stalled frames
// with tx_err after TIMEOUT_CYCLES; without it the FSM waits for the device.
`timescale 1ns/1ps

module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned INHIBIT_CYCLES = 12_000,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  input  logic       PS2_clk_i,
  input  logic       PS2_data_i,
  output logic       PS2_clk_oe,
  output logic       PS2_data_oe
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

`ifdef PS2_TX_TIMEOUT_EN
  localparam bit WATCHDOG_EN = 1'b1;
`else
  localparam bit WATCHDOG_EN = 1'b0;
`endif

  // The device needs at least 100 us of clock inhibit to notice a host request.
  if (INHIBIT_CYCLES < CLK_HZ / 10_000) begin : g_inhibit_check
    $error("ps2_host_tx: INHIBIT_CYCLES is shorter than 100 us at CLK_HZ");
  end

  logic clk_sync, data_sync, clk_fall;

  ps2_line_sync u_line_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk_i  (PS2_clk_i),
    .ps2_data_i (PS2_data_i),
    .clk_sync   (clk_sync),
    .data_sync  (data_sync),
    .clk_fall   (clk_fall)
  );

  ps2_tx_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       idx_q, idx_d;
  logic [7:0]       byte_q, byte_d;
  logic             par_q, par_d;
  logic             clk_oe_q, clk_oe_d;
  logic             data_oe_q, data_oe_d;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             frame_bit;
  logic             watching;
  logic             expire;

  // Next-state logic: walks one frame and computes every registered output.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    byte_d    = byte_q;
    par_d     = par_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    ready_d   = ready_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    frame_bit = 1'b1;
    if (idx_q < PS2_PARITY_IDX) begin
      frame_bit = byte_q[idx_q[2:0]];
    end else if (idx_q == PS2_PARITY_IDX) begin
      frame_bit = par_q;
    end

    watching = (state_q == SEND) || (state_q == ACK) || (state_q == WAIT_IDLE);
    expire   = WATCHDOG_EN && watching && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    if (watching) begin
      cnt_d = WATCHDOG_EN ? cnt_q + CNT_W'(1) : '0;
    end

    if (expire) begin
      state_d   = IDLE;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      err_d     = 1'b1;
      cnt_d     = '0;
      idx_d     = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          ready_d   = 1'b1;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
          if (tx_valid && ready_q) begin
            byte_d   = tx_data;
            par_d    = ps2_odd_parity(tx_data);
            cnt_d    = '0;
            idx_d    = '0;
            ready_d  = 1'b0;
            clk_oe_d = 1'b1;
            state_d  = INHIBIT;
          end
        end
        INHIBIT: begin
          if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
            state_d   = START;
            data_oe_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        START: begin
          state_d  = SEND;
          clk_oe_d = 1'b0;
          cnt_d    = '0;
          idx_d    = '0;
        end
        SEND: begin
          if (clk_fall) begin
            data_oe_d = ~frame_bit;
            idx_d     = idx_q + 4'd1;
            if (idx_q == PS2_STOP_IDX) begin
              state_d = ACK;
            end
          end
        end
        ACK: begin
          if (clk_fall) begin
            if (data_sync) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = WAIT_IDLE;
            end
          end
        end
        WAIT_IDLE: begin
          if (clk_sync && data_sync) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          state_d   = IDLE;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers; reset releases both lines immediately.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      byte_q    <= '0;
      par_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      byte_q    <= byte_d;
      par_q     <= par_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign tx_ready    = ready_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign PS2_clk_oe  = clk_oe_q;
  assign PS2_data_oe = data_oe_q;

endmodule
